// File: rtl/rs_alloc_ctrl_pkg.sv
// Shared definitions for the reservation-station allocation controller.
// Purpose : per-RS-type entry-count constants used as parameter defaults,
//           plus the dispatch slot-mode encoding used by the entry steering.
// Ports   : none (package).
package rs_alloc_ctrl_pkg;

    // Entry counts / index widths per reservation-station type.
    localparam int RS_ALU_ENT_NUM    = 8;
    localparam int RS_ALU_ENT_SEL    = 3;
    localparam int RS_MUL_ENT_NUM    = 4;
    localparam int RS_MUL_ENT_SEL    = 2;
    localparam int RS_LDST_ENT_NUM   = 8;
    localparam int RS_LDST_ENT_SEL   = 3;
    localparam int RS_BRANCH_ENT_NUM = 4;
    localparam int RS_BRANCH_ENT_SEL = 2;

    // Which dispatch slots target this RS this cycle, as {req2, req1}.
    typedef enum logic [1:0] {
        SLOT_NONE   = 2'b00,
        SLOT_1_ONLY = 2'b01,
        SLOT_2_ONLY = 2'b10,
        SLOT_BOTH   = 2'b11
    } slot_mode_e;

endpackage

// File: rtl/rs_rrselect.sv
// Round-robin selector.
// Purpose : picks the first set bit of vec at or above ptr, wrapping past
//           the top index back to 0.
// Ports   : vec   - candidate bit vector
//           ptr   - starting index of the search
//           valid - any bit of vec set
//           sel   - chosen index (0 when valid=0)
module rs_rrselect #(
    parameter int ENT_NUM = 8,
    parameter int ENT_SEL = 3
) (
    input  logic [ENT_NUM-1:0] vec,
    input  logic [ENT_SEL-1:0] ptr,
    output logic               valid,
    output logic [ENT_SEL-1:0] sel
);

    logic               found;
    logic [ENT_SEL-1:0] idx;

    always_comb begin
        valid = |vec;
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            // ENT_NUM is a power of two, so the index addition wraps on its own.
            idx = ptr + ENT_SEL'(i);
            if (!found && vec[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_alloc_ctrl.sv
// Reservation-station allocation / issue controller.
// Purpose : tracks entry occupancy, hands out up to two free entries per
//           cycle to the dispatch slots (all-or-nothing), and selects one
//           busy+ready entry per cycle for issue in round-robin order.
// Ports   : clk, reset (async, active-low)
//           req1/req2/req_num  - dispatch requests and their count
//           stall_in, kill     - dispatch stall, full flush
//           ready_vec          - per-entry operands-ready
//           issue_ack          - functional unit takes issue_sel
//           allocatable, we1/we2, alloc_ent1/alloc_ent2 - allocation result
//           busy_vec, free_cnt - registered occupancy state
//           issue_valid, issue_sel - issue selection
module rs_alloc_ctrl
    import rs_alloc_ctrl_pkg::*;
#(
    parameter int ENT_NUM = RS_ALU_ENT_NUM,
    parameter int ENT_SEL = RS_ALU_ENT_SEL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req1,
    input  logic               req2,
    input  logic [1:0]         req_num,
    input  logic               stall_in,
    input  logic               kill,
    input  logic [ENT_NUM-1:0] ready_vec,
    input  logic               issue_ack,
    output logic               allocatable,
    output logic               we1,
    output logic               we2,
    output logic [ENT_SEL-1:0] alloc_ent1,
    output logic [ENT_SEL-1:0] alloc_ent2,
    output logic [ENT_NUM-1:0] busy_vec,
    output logic [ENT_SEL:0]   free_cnt,
    output logic               issue_valid,
    output logic [ENT_SEL-1:0] issue_sel
);

    localparam int CW = ENT_SEL + 1;

    logic [ENT_NUM-1:0] busy_q, busy_d;
    logic [CW-1:0]      free_cnt_q, free_cnt_d;
    logic [ENT_SEL-1:0] rr_ptr_q, rr_ptr_d;

    logic [ENT_SEL-1:0] free_a, free_b;
    logic               found_a, found_b;
    logic               fire;
    slot_mode_e         mode;
    logic [ENT_NUM-1:0] candidates;
    logic               cand_valid;
    logic [ENT_SEL-1:0] cand_sel;
    logic               issue_fire;

    // Lowest (A) and second-lowest (B) free entries from registered state only,
    // so entries released this cycle are not reused until the next one.
    always_comb begin
        free_a  = '0;
        free_b  = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        for (int i = 0; i < ENT_NUM; i++) begin
            if (!busy_q[i]) begin
                if (!found_a) begin
                    free_a  = ENT_SEL'(i);
                    found_a = 1'b1;
                end else if (!found_b) begin
                    free_b  = ENT_SEL'(i);
                    found_b = 1'b1;
                end
            end
        end
    end

    // All-or-nothing: if both slots cannot be served, neither is.
    assign allocatable = (free_cnt_q >= CW'(req_num));
    assign fire        = allocatable & ~stall_in & ~kill;
    assign we1         = req1 & fire;
    assign we2         = req2 & fire;
    assign mode        = slot_mode_e'({req2, req1});

    always_comb begin
        alloc_ent1 = '0;
        alloc_ent2 = '0;
        case (mode)
            SLOT_BOTH: begin
                alloc_ent1 = free_a;
                alloc_ent2 = free_b;
            end
            SLOT_1_ONLY: alloc_ent1 = free_a;
            SLOT_2_ONLY: alloc_ent2 = free_a;
            default: ;
        endcase
    end

    // Only registered occupancy feeds issue: no same-cycle alloc-to-issue path.
    assign candidates = busy_q & ready_vec;

    rs_rrselect #(
        .ENT_NUM (ENT_NUM),
        .ENT_SEL (ENT_SEL)
    ) u_rrselect (
        .vec   (candidates),
        .ptr   (rr_ptr_q),
        .valid (cand_valid),
        .sel   (cand_sel)
    );

    assign issue_valid = cand_valid & ~kill;
    assign issue_sel   = cand_sel;
    assign issue_fire  = issue_valid & issue_ack;

    // Allocated entries are free and issued ones busy, so the set and clear
    // below never touch the same bit.
    always_comb begin
        busy_d     = busy_q;
        free_cnt_d = free_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        if (kill) begin
            busy_d     = '0;
            free_cnt_d = CW'(ENT_NUM);
            rr_ptr_d   = '0;
        end else begin
            if (we1) busy_d[alloc_ent1] = 1'b1;
            if (we2) busy_d[alloc_ent2] = 1'b1;
            if (issue_fire) begin
                busy_d[issue_sel] = 1'b0;
                rr_ptr_d          = issue_sel + 1'b1;
            end
            free_cnt_d = free_cnt_q + CW'(issue_fire) - CW'(we1) - CW'(we2);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q     <= '0;
            free_cnt_q <= CW'(ENT_NUM);
            rr_ptr_q   <= '0;
        end else begin
            busy_q     <= busy_d;
            free_cnt_q <= free_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign busy_vec = busy_q;
    assign free_cnt = free_cnt_q;

endmodule

// File: tb/tb_rs_alloc_ctrl.sv
// Testbench for rs_alloc_ctrl (ENT_NUM=8): directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_rs_alloc_ctrl;

    localparam int N = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         req1, req2, stall_in, kill, issue_ack;
    logic [1:0]   req_num;
    logic [N-1:0] ready_vec;
    logic         allocatable, we1, we2, issue_valid;
    logic [S-1:0] alloc_ent1, alloc_ent2, issue_sel;
    logic [N-1:0] busy_vec;
    logic [S:0]   free_cnt;

    always #5 clk = ~clk;

    rs_alloc_ctrl #(.ENT_NUM(N), .ENT_SEL(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .req1        (req1),
        .req2        (req2),
        .req_num     (req_num),
        .stall_in    (stall_in),
        .kill        (kill),
        .ready_vec   (ready_vec),
        .issue_ack   (issue_ack),
        .allocatable (allocatable),
        .we1         (we1),
        .we2         (we2),
        .alloc_ent1  (alloc_ent1),
        .alloc_ent2  (alloc_ent2),
        .busy_vec    (busy_vec),
        .free_cnt    (free_cnt),
        .issue_valid (issue_valid),
        .issue_sel   (issue_sel)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic r1, input logic r2, input logic st, input logic kl,
                         input logic [N-1:0] rdy, input logic ack);
        req1      = r1;
        req2      = r2;
        req_num   = {1'b0, r1} + {1'b0, r2};
        stall_in  = st;
        kill      = kl;
        ready_vec = rdy;
        issue_ack = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         r1, r2, st, kl;
        logic [N-1:0] rdy;
        logic         ack;
        logic         e_alloc, e_we1, e_we2;
        logic [S-1:0] e_ent1, e_ent2;
        logic         e_iv;
        logic [S-1:0] e_isel;
        logic [N-1:0] e_busy;
        logic [S:0]   e_free;
    } vec_t;

    vec_t tbl[8];

    // Behavioural model state
    bit  mb[N];
    int  mrr;
    int  fl[$];

    initial begin
        // Sequence from reset: allocation order, stall, round-robin issue, wrap.
        tbl[0] = '{1'b1,1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b1,1'b1,3'd0,3'd1,1'b0,3'd0,8'h03,4'd6};
        tbl[1] = '{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,1'b1,3'd0,3'd2,1'b0,3'd0,8'h07,4'd5};
        tbl[2] = '{1'b1,1'b0,1'b0,1'b0,8'h02,1'b1, 1'b1,1'b1,1'b0,3'd3,3'd0,1'b1,3'd1,8'h0D,4'd5};
        tbl[3] = '{1'b1,1'b1,1'b1,1'b0,8'h0D,1'b0, 1'b1,1'b0,1'b0,3'd1,3'd4,1'b1,3'd2,8'h0D,4'd5};
        tbl[4] = '{1'b0,1'b0,1'b0,1'b0,8'h0D,1'b1, 1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,3'd2,8'h09,4'd6};
        tbl[5] = '{1'b0,1'b0,1'b0,1'b0,8'h09,1'b1, 1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,3'd3,8'h01,4'd7};
        tbl[6] = '{1'b0,1'b0,1'b0,1'b0,8'h01,1'b1, 1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,3'd0,8'h00,4'd8};
        tbl[7] = '{1'b0,1'b0,1'b0,1'b0,8'hFF,1'b1, 1'b1,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,8'h00,4'd8};

        // Reset state
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_vec), 32'h0);
        chk("rst_free", 32'(free_cnt), 32'd8);
        chk("rst_iv", 32'(issue_valid), 32'd0);
        chk("rst_alloc_reqnum0", 32'(allocatable), 32'd1);
        @(negedge clk) reset = 1'b1;
        tick();

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].r1, tbl[i].r2, tbl[i].st, tbl[i].kl, tbl[i].rdy, tbl[i].ack);
            @(negedge clk);
            chk($sformatf("t%0d_alloc", i), 32'(allocatable), 32'(tbl[i].e_alloc));
            chk($sformatf("t%0d_we1", i), 32'(we1), 32'(tbl[i].e_we1));
            chk($sformatf("t%0d_we2", i), 32'(we2), 32'(tbl[i].e_we2));
            chk($sformatf("t%0d_ent1", i), 32'(alloc_ent1), 32'(tbl[i].e_ent1));
            chk($sformatf("t%0d_ent2", i), 32'(alloc_ent2), 32'(tbl[i].e_ent2));
            chk($sformatf("t%0d_iv", i), 32'(issue_valid), 32'(tbl[i].e_iv));
            chk($sformatf("t%0d_isel", i), 32'(issue_sel), 32'(tbl[i].e_isel));
            tick();
            chk($sformatf("t%0d_busy", i), 32'(busy_vec), 32'(tbl[i].e_busy));
            chk($sformatf("t%0d_free", i), 32'(free_cnt), 32'(tbl[i].e_free));
        end

        // Full RS: request blocked, then a freed entry is reused
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
            tick();
        end
        chk("full_busy", 32'(busy_vec), 32'hFF);
        chk("full_free", 32'(free_cnt), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("full_alloc", 32'(allocatable), 32'd0);
        chk("full_we1", 32'(we1), 32'd0);
        tick();
        chk("full_busy_hold", 32'(busy_vec), 32'hFF);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1);
        @(negedge clk);
        chk("full_iv", 32'(issue_valid), 32'd1);
        chk("full_isel", 32'(issue_sel), 32'd3);
        tick();
        chk("freed_free", 32'(free_cnt), 32'd1);
        chk("freed_busy", 32'(busy_vec), 32'hF7);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("reuse_we1", 32'(we1), 32'd1);
        chk("reuse_ent1", 32'(alloc_ent1), 32'd3);
        tick();
        chk("reuse_busy", 32'(busy_vec), 32'hFF);

        // One free entry, two requests: no partial dispatch
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1);
        @(negedge clk);
        chk("one_isel", 32'(issue_sel), 32'd5);
        tick();
        chk("one_free", 32'(free_cnt), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("one_alloc2", 32'(allocatable), 32'd0);
        chk("one_we1", 32'(we1), 32'd0);
        chk("one_we2", 32'(we2), 32'd0);
        tick();
        chk("one_busy_hold", 32'(busy_vec), 32'hDF);
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("one_r2_we2", 32'(we2), 32'd1);
        chk("one_r2_ent2", 32'(alloc_ent2), 32'd5);
        tick();
        chk("one_r2_busy", 32'(busy_vec), 32'hFF);

        // Kill with simultaneous allocation and ack (rr_ptr is 6 before this)
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
        @(negedge clk);
        chk("kill_we1", 32'(we1), 32'd0);
        chk("kill_we2", 32'(we2), 32'd0);
        chk("kill_iv", 32'(issue_valid), 32'd0);
        tick();
        chk("kill_busy", 32'(busy_vec), 32'h0);
        chk("kill_free", 32'(free_cnt), 32'd8);

        // Round robin from pointer 0 over candidates 0x81
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1);
        @(negedge clk);
        chk("rr_sel0_iv", 32'(issue_valid), 32'd1);
        chk("rr_sel0", 32'(issue_sel), 32'd0);
        tick();
        @(negedge clk);
        chk("rr_sel7", 32'(issue_sel), 32'd7);
        tick();
        @(negedge clk);
        chk("rr_empty_iv", 32'(issue_valid), 32'd0);
        chk("rr_busy", 32'(busy_vec), 32'h7E);

        // Reset mid-operation discards in-flight allocation
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_vec), 32'h0);
        chk("arst_free", 32'(free_cnt), 32'd8);
        tick();
        chk("arst_hold_busy", 32'(busy_vec), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk) reset = 1'b1;
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("arst_ent1", 32'(alloc_ent1), 32'd0);
        chk("arst_ent2", 32'(alloc_ent2), 32'd1);
        tick();
        chk("arst_busy_after", 32'(busy_vec), 32'h03);

        // Randomized traffic against the behavioural model
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) mb[i] = 1'b0;
        mrr = 0;
        @(negedge clk) reset = 1'b1;
        tick();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic         r1, r2, st, kl, ack;
            logic [N-1:0] rdy, eb;
            bit           e_alloc, fire, found, e_iv;
            int           rn, e1, e2, e_isel, idx;
            r1  = 1'($urandom_range(0, 1));
            r2  = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 7) == 0);
            kl  = ($urandom_range(0, 63) == 0);
            ack = 1'($urandom_range(0, 1));
            rdy = N'($urandom);
            drive(r1, r2, st, kl, rdy, ack);

            fl.delete();
            for (int i = 0; i < N; i++) if (!mb[i]) fl.push_back(i);
            rn      = int'(r1) + int'(r2);
            e_alloc = (fl.size() >= rn);
            fire    = e_alloc && !st && !kl;
            e1      = (fl.size() > 0) ? fl[0] : 0;
            e2      = (r1 && fl.size() > 1) ? fl[1] : e1;
            found   = 1'b0;
            e_isel  = 0;
            for (int k = 0; k < N; k++) begin
                idx = (mrr + k) % N;
                if (!found && mb[idx] && rdy[idx]) begin
                    found  = 1'b1;
                    e_isel = idx;
                end
            end
            e_iv = found && !kl;

            @(negedge clk);
            chk("rnd_alloc", 32'(allocatable), 32'(e_alloc));
            chk("rnd_we1", 32'(we1), 32'(r1 && fire));
            chk("rnd_we2", 32'(we2), 32'(r2 && fire));
            if (e_alloc && r1) chk("rnd_ent1", 32'(alloc_ent1), 32'(e1));
            if (e_alloc && r2) chk("rnd_ent2", 32'(alloc_ent2), 32'(e2));
            chk("rnd_iv", 32'(issue_valid), 32'(e_iv));
            chk("rnd_isel", 32'(issue_sel), 32'(e_isel));
            if (we1) chk("rnd_alloc_busy1", 32'(busy_vec[alloc_ent1]), 32'd0);
            if (we2) chk("rnd_alloc_busy2", 32'(busy_vec[alloc_ent2]), 32'd0);

            if (kl) begin
                for (int i = 0; i < N; i++) mb[i] = 1'b0;
                mrr = 0;
            end else begin
                if (fire && r1) mb[e1] = 1'b1;
                if (fire && r2) mb[e2] = 1'b1;
                if (e_iv && ack) begin
                    mb[e_isel] = 1'b0;
                    mrr = (e_isel + 1) % N;
                end
            end

            tick();
            for (int i = 0; i < N; i++) eb[i] = mb[i];
            chk("rnd_busy", 32'(busy_vec), 32'(eb));
            chk("rnd_free", 32'(free_cnt), 32'(N - $countones(eb)));
            chk("rnd_free_inv", 32'(free_cnt), 32'(N - $countones(busy_vec)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
